// File: rtl/nv_nvdla_cvif_write_eg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nv_nvdla_cvif_write_eg_pkg : shared CVIF constants for write egress |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package nv_nvdla_cvif_write_eg_pkg;

    localparam int C_NUM_THREADS = 5;
    localparam int C_TID_W       = 4;
    localparam int C_CQ_PD_W     = 3;
    localparam int C_LEN_W       = 2;
    localparam int C_PD_ACK_BIT  = 0;
    localparam int C_PD_LEN_LSB  = 1;
    localparam int C_PD_LEN_MSB  = 2;

    localparam int C_THR_BDMA = 0;
    localparam int C_THR_SDP  = 1;
    localparam int C_THR_PDP  = 2;
    localparam int C_THR_CDP  = 3;
    localparam int C_THR_RBK  = 4;

endpackage : nv_nvdla_cvif_write_eg_pkg
`default_nettype wire

// File: rtl/nv_nvdla_cvif_write_eg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nv_nvdla_cvif_write_eg : AXI B-channel egress, pops context queues  |
// | and returns credits / write-complete pulses. Rev 1.0               |
// +--------------------------------------------------------------------+
module nv_nvdla_cvif_write_eg
    import nv_nvdla_cvif_write_eg_pkg::*;
(
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 noc2cvif_axi_b_bvalid,
    output logic                 noc2cvif_axi_b_bready,
    input  logic [7:0]           noc2cvif_axi_b_bid,
    input  logic                 cq_rd0_pvld,
    output logic                 cq_rd0_prdy,
    input  logic [C_CQ_PD_W-1:0] cq_rd0_pd,
    input  logic                 cq_rd1_pvld,
    output logic                 cq_rd1_prdy,
    input  logic [C_CQ_PD_W-1:0] cq_rd1_pd,
    input  logic                 cq_rd2_pvld,
    output logic                 cq_rd2_prdy,
    input  logic [C_CQ_PD_W-1:0] cq_rd2_pd,
    input  logic                 cq_rd3_pvld,
    output logic                 cq_rd3_prdy,
    input  logic [C_CQ_PD_W-1:0] cq_rd3_pd,
    input  logic                 cq_rd4_pvld,
    output logic                 cq_rd4_prdy,
    input  logic [C_CQ_PD_W-1:0] cq_rd4_pd,
    output logic                 eg2ig_axi_vld,
    output logic [C_LEN_W-1:0]   eg2ig_axi_len,
    output logic                 cvif2bdma_wr_rsp_complete,
    output logic                 cvif2sdp_wr_rsp_complete,
    output logic                 cvif2pdp_wr_rsp_complete,
    output logic                 cvif2cdp_wr_rsp_complete,
    output logic                 cvif2rbk_wr_rsp_complete,
    output logic                 eg_err_bad_id
);

    logic                     r_hold_vld;
    logic [C_TID_W-1:0]       r_hold_tid;
    logic                     r_eg_vld;
    logic [C_LEN_W-1:0]       r_eg_len;
    logic [C_NUM_THREADS-1:0] r_cmpl;
    logic                     r_err;

    logic [C_NUM_THREADS-1:0] w_pvld;
    logic [C_CQ_PD_W-1:0]     w_pd [C_NUM_THREADS];
    logic [C_NUM_THREADS-1:0] w_sel;
    logic [C_NUM_THREADS-1:0] w_pop_vec;
    logic [C_NUM_THREADS-1:0] w_pop_ack;
    logic [C_LEN_W-1:0]       w_pop_len;
    logic                     w_pop;
    logic                     w_bad;
    logic                     w_s1_done;
    logic                     w_b_fire;
    logic                     w_bid_unused;

    assign w_pvld = {cq_rd4_pvld, cq_rd3_pvld, cq_rd2_pvld, cq_rd1_pvld, cq_rd0_pvld};
    assign w_pd[0] = cq_rd0_pd;
    assign w_pd[1] = cq_rd1_pd;
    assign w_pd[2] = cq_rd2_pd;
    assign w_pd[3] = cq_rd3_pd;
    assign w_pd[4] = cq_rd4_pd;
    assign w_bid_unused = ^noc2cvif_axi_b_bid[7:4];

    // Decode and pop mux depend only on the held response, never on bvalid.
    always_comb begin
        w_sel     = '0;
        w_pop_len = '0;
        w_pop_ack = '0;
        for (int n = 0; n < C_NUM_THREADS; n++) begin
            w_sel[n] = r_hold_vld && (r_hold_tid == C_TID_W'(n));
        end
        w_pop_vec = w_sel & w_pvld;
        for (int n = 0; n < C_NUM_THREADS; n++) begin
            if (w_pop_vec[n]) begin
                w_pop_len    = w_pd[n][C_PD_LEN_MSB:C_PD_LEN_LSB];
                w_pop_ack[n] = w_pd[n][C_PD_ACK_BIT];
            end
        end
    end

    assign w_pop     = |w_pop_vec;
    assign w_bad     = r_hold_vld && (r_hold_tid >= C_TID_W'(C_NUM_THREADS));
    assign w_s1_done = w_pop || w_bad;
    assign w_b_fire  = noc2cvif_axi_b_bvalid && noc2cvif_axi_b_bready;

    assign noc2cvif_axi_b_bready = !r_hold_vld || w_s1_done;
    assign cq_rd0_prdy = w_pop_vec[0];
    assign cq_rd1_prdy = w_pop_vec[1];
    assign cq_rd2_prdy = w_pop_vec[2];
    assign cq_rd3_prdy = w_pop_vec[3];
    assign cq_rd4_prdy = w_pop_vec[4];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_hold_vld <= 1'b0;
            r_hold_tid <= '0;
            r_eg_vld   <= 1'b0;
            r_eg_len   <= '0;
            r_cmpl     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_b_fire) begin
                r_hold_vld <= 1'b1;
                r_hold_tid <= noc2cvif_axi_b_bid[C_TID_W-1:0];
            end else if (w_s1_done) begin
                r_hold_vld <= 1'b0;
            end
            r_eg_vld <= w_pop;
            r_eg_len <= w_pop_len;
            r_cmpl   <= w_pop_ack;
            r_err    <= r_err || w_bad;
        end
    end

    assign eg2ig_axi_vld             = r_eg_vld;
    assign eg2ig_axi_len             = r_eg_len;
    assign cvif2bdma_wr_rsp_complete = r_cmpl[C_THR_BDMA];
    assign cvif2sdp_wr_rsp_complete  = r_cmpl[C_THR_SDP];
    assign cvif2pdp_wr_rsp_complete  = r_cmpl[C_THR_PDP];
    assign cvif2cdp_wr_rsp_complete  = r_cmpl[C_THR_CDP];
    assign cvif2rbk_wr_rsp_complete  = r_cmpl[C_THR_RBK];
    assign eg_err_bad_id             = r_err;

endmodule : nv_nvdla_cvif_write_eg
`default_nettype wire
